// File: rtl/song_pkg.sv
// song_pkg: shared event format for the song store (recorder and auto-play reader)
package song_pkg;
  typedef enum logic [2:0] {NOTE_REST, NOTE_DO, NOTE_RE, NOTE_MI, NOTE_FA, NOTE_SOL, NOTE_LA, NOTE_SI} note_e;
  typedef enum logic [1:0] {OCT_LOW = 2'b00, OCT_MID = 2'b01, OCT_HIGH = 2'b10} oct_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RECORD, ST_FLUSH} rec_state_e;
  localparam int NOTE_W = 3;
  localparam int OCT_W = 2;
  localparam int CODE_W = OCT_W + NOTE_W;
  localparam int NOTE_LSB = 0;
  localparam int OCT_LSB = NOTE_W;
  function automatic int evt_w(input int dur_w);
    return CODE_W + dur_w;
  endfunction
endpackage

// File: rtl/key_event_encoder.sv
// key_event_encoder: keys + octave keys -> {octave,note} event code
// key_i  : note keys, bit0=Do .. bit6=Si, lowest pressed key wins
// oct_i  : bit0=high, bit1=low, none/both = middle
// code_o : {octave,note}; rests always carry the middle octave
module key_event_encoder
  import song_pkg::*;
(
  input  logic [6:0]        key_i,
  input  logic [1:0]        oct_i,
  output logic [CODE_W-1:0] code_o
);
  note_e note;
  oct_e  oct;
  always_comb begin
    note = NOTE_REST;
    for (int i = 6; i >= 0; i--) note = key_i[i] ? note_e'(3'(i + 1)) : note;
    oct = (note == NOTE_REST || oct_i == 2'b00 || oct_i == 2'b11) ? OCT_MID : (oct_i[0] ? OCT_HIGH : OCT_LOW);
    code_o = '0;
    code_o[OCT_LSB +: OCT_W] = oct;
    code_o[NOTE_LSB +: NOTE_W] = note;
  end
endmodule

// File: rtl/key_recorder.sv
// key_recorder: records live key play as {octave,note,duration} events into a buffer
// clk, reset            : clock, async active-high reset
// key_in, octave_keys   : live keyboard inputs
// record_en             : level, high while recording a take
// rd_addr / rd_data     : registered read port, 1-cycle latency
// event_count, full     : events stored in the take, overflow flag
// recording             : high while in RECORD
module key_recorder
  import song_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int DEPTH = 64,
  parameter int DUR_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              key_in,
  input  logic [1:0]              octave_keys,
  input  logic                    record_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [CODE_W+DUR_W-1:0] rd_data,
  output logic [AW:0]             event_count,
  output logic                    recording,
  output logic                    full
);
  localparam int EW = evt_w(DUR_W);
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  rec_state_e state_q, state_d;
  logic rec_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, full_d;
  logic [CODE_W-1:0] evt_q, evt_d, sample;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_q;
  logic start, tick, wr_req, we;

  key_event_encoder u_enc (.key_i(key_in), .oct_i(octave_keys), .code_o(sample));

  assign start = state_q == ST_IDLE && record_en && !rec_q;
  assign tick = tick_q == TICK_LAST;
  assign we = wr_req && cnt_q != CNT_FULL;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    full_d = full_q;
    evt_d = evt_q;
    dur_d = dur_q;
    wr_req = 1'b0;
    tick_d = (start || tick) ? '0 : tick_q + 1'b1;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RECORD;
        cnt_d = '0;
        full_d = 1'b0;
        evt_d = sample;
        dur_d = '0;
      end
      ST_RECORD: begin
        // a changed sample or a saturated duration both close the current event
        if (tick) begin
          if (sample == evt_q && dur_q != DUR_MAX) dur_d = dur_q + 1'b1;
          else begin
            wr_req = dur_q != '0;
            evt_d = sample;
            dur_d = DUR_W'(1);
          end
        end
        if (!record_en) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        wr_req = dur_q != '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (wr_req) begin
      if (we) cnt_d = cnt_q + 1'b1;
      else full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rec_q <= 1'b0;
      tick_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      evt_q <= '0;
      dur_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      rec_q <= record_en;
      tick_q <= tick_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      evt_q <= evt_d;
      dur_q <= dur_d;
      rd_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) if (we) mem[cnt_q[AW-1:0]] <= {evt_q, dur_q};

  assign rd_data = rd_q;
  assign event_count = cnt_q;
  assign full = full_q;
  assign recording = state_q == ST_RECORD;
endmodule

// File: tb/tb_key_recorder.sv
// tb_key_recorder: self-checking bench for key_recorder
module tb_key_recorder;
  localparam int TC = 4;
  localparam int DP = 4;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int EW = 5 + DW;
  logic clk = 1'b0;
  logic reset, record_en, recording, full;
  logic [6:0] key_in;
  logic [1:0] octave_keys;
  logic [AW-1:0] rd_addr;
  logic [EW-1:0] rd_data;
  logic [AW:0] event_count;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {logic [6:0] k; logic [1:0] o;} smp_t;
  typedef struct {logic [6:0] k; logic [1:0] o; logic [4:0] code;} vec_t;
  smp_t s0;
  smp_t sq[$];
  logic [EW-1:0] exp_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  key_recorder #(.TICK_CYCLES(TC), .DEPTH(DP), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .octave_keys(octave_keys), .record_en(record_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .event_count(event_count), .recording(recording), .full(full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] enc(input smp_t s);
    int n = 0;
    logic [1:0] oc;
    for (int b = 0; b < 7; b++) if (n == 0 && s.k[b]) n = b + 1;
    oc = (n == 0) ? 2'b01 : (s.o == 2'b01) ? 2'b10 : (s.o == 2'b10) ? 2'b00 : 2'b01;
    return {oc, 3'(n)};
  endfunction

  task automatic build_model();
    int i = 0;
    exp_q.delete();
    while (i < sq.size()) begin
      int j = i;
      int len;
      logic [4:0] c = enc(sq[i]);
      while (j < sq.size() && enc(sq[j]) == c) j++;
      len = j - i;
      while (len > 0) begin
        int d = len > 15 ? 15 : len;
        exp_q.push_back({c, 4'(d)});
        len -= d;
      end
      i = j;
    end
  endtask

  task automatic hold(input logic [6:0] k, input logic [1:0] o, input int n);
    smp_t s;
    s.k = k;
    s.o = o;
    repeat (n) sq.push_back(s);
  endtask

  task automatic rd(input int a, output logic [EW-1:0] d);
    @(negedge clk);
    rd_addr = AW'(a);
    @(posedge clk);
    #1 d = rd_data;
  endtask

  task automatic run_take(input bit fall_same, input bit rerise);
    @(negedge clk);
    key_in = s0.k;
    octave_keys = s0.o;
    record_en = 1'b1;
    @(posedge clk);
    #1 chk("rec_start", recording, 1);
    foreach (sq[i]) begin
      @(negedge clk);
      key_in = sq[i].k;
      octave_keys = sq[i].o;
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (fall_same && i == sq.size() - 1) record_en = 1'b0;
      @(posedge clk);
    end
    if (!fall_same) begin
      @(negedge clk);
      record_en = 1'b0;
      @(posedge clk);
    end
    #1 chk("rec_fall", recording, 0);
    if (rerise) begin
      @(negedge clk);
      record_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("rerise_ignored", recording, 0);
      @(negedge clk);
      record_en = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_take(input string tag);
    logic [EW-1:0] d;
    int n;
    build_model();
    n = exp_q.size() > DP ? DP : exp_q.size();
    chk({tag, "_count"}, event_count, n);
    chk({tag, "_full"}, full, exp_q.size() > DP);
    for (int a = 0; a < n; a++) begin
      rd(a, d);
      chk($sformatf("%s_mem%0d", tag, a), d, exp_q[a]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] d, prev;
    smp_t pool[3];
    smp_t cur;
    tbl[0] = '{7'b0000001, 2'b00, 5'b01_001};
    tbl[1] = '{7'b0000011, 2'b00, 5'b01_001};
    tbl[2] = '{7'b0000100, 2'b01, 5'b10_011};
    tbl[3] = '{7'b1000000, 2'b10, 5'b00_111};
    tbl[4] = '{7'b0000000, 2'b01, 5'b01_000};
    tbl[5] = '{7'b0100000, 2'b11, 5'b01_110};
    tbl[6] = '{7'b0011000, 2'b10, 5'b00_100};
    tbl[7] = '{7'b1111111, 2'b01, 5'b10_001};
    reset = 1'b1;
    record_en = 1'b0;
    key_in = '0;
    octave_keys = '0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", event_count, 0);
    chk("rst_full", full, 0);
    chk("rst_recording", recording, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    s0 = '{7'b0000001, 2'b00};
    sq.delete();
    hold(7'b0000001, 2'b00, 3);
    run_take(0, 0);
    check_take("t1");
    rd(0, d);
    chk("t1_const", d, 9'b01_001_0011);
    s0 = '{7'b0000100, 2'b00};
    sq.delete();
    hold(7'b0000100, 2'b00, 2);
    hold(7'b0000000, 2'b00, 1);
    hold(7'b1000000, 2'b01, 2);
    run_take(0, 1);
    check_take("t2");
    rd(2, d);
    chk("t2_const", d, 9'b10_111_0010);
    s0 = '{7'b0000010, 2'b00};
    sq.delete();
    hold(7'b0000010, 2'b00, 20);
    run_take(1, 0);
    check_take("t3");
    rd(0, d);
    chk("t3_const0", d, 9'b01_010_1111);
    rd(1, d);
    chk("t3_const1", d, 9'b01_010_0101);
    s0 = '{7'b0000001, 2'b00};
    sq.delete();
    for (int i = 0; i < 6; i++) hold(i % 2 ? 7'b0000001 : 7'b0001000, 2'b00, 1);
    run_take(0, 0);
    check_take("t4");
    chk("t4_full_const", full, 1);
    prev = exp_q[3];
    for (int a = 0; a < DP; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      #1 chk($sformatf("lat_hold%0d", a), rd_data, prev);
      @(posedge clk);
      #1 chk($sformatf("lat_data%0d", a), rd_data, exp_q[a]);
      prev = exp_q[a];
    end
    sq.delete();
    hold(7'b0000001, 2'b00, 1);
    run_take(0, 0);
    check_take("t4_next");
    foreach (tbl[i]) begin
      s0 = '{tbl[i].k, tbl[i].o};
      sq.delete();
      sq.push_back(s0);
      run_take(0, 0);
      rd(0, d);
      chk($sformatf("tbl%0d_evt", i), d, {tbl[i].code, 4'd1});
      chk($sformatf("tbl%0d_count", i), event_count, 1);
    end
    @(negedge clk);
    key_in = 7'b0000001;
    octave_keys = 2'b00;
    record_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_in = 7'b0000010 << i;
      repeat (4) @(posedge clk);
      #1;
      if (i == 2) chk("rst_mid_count", event_count, 2);
    end
    chk("rst_mid_full", full, 1);
    chk("rst_mid_recording", recording, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_count", event_count, 0);
    chk("rst_async_recording", recording, 0);
    chk("rst_async_full", full, 0);
    @(negedge clk);
    reset = 1'b0;
    record_en = 1'b0;
    key_in = '0;
    for (int t = 0; t < 20; t++) begin
      foreach (pool[p]) begin
        pool[p].k = ($urandom % 4 == 0) ? 7'b0 : 7'($urandom_range(0, 127));
        pool[p].o = 2'($urandom_range(0, 3));
      end
      s0 = pool[$urandom % 3];
      cur = pool[$urandom % 3];
      sq.delete();
      repeat ($urandom_range(1, 24)) begin
        if ($urandom % 4 == 0) cur = pool[$urandom % 3];
        sq.push_back(cur);
      end
      run_take(1'($urandom % 2), 0);
      check_take($sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
